// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier: WIDTH cycles from accept to a
// registered 2*WIDTH-bit product, with a start/busy/done handshake.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   inputP,
    input  logic [WIDTH-1:0]   inputQ,
    output logic [2*WIDTH-1:0] product,
    output logic               productOverflow,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        count_d    = count_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        partial  = {{WIDTH{1'b0}}, mcand_q} << count_q;
        acc_next = mplier_q[0] ? acc_q + partial : acc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = inputP;
                    mplier_d = inputQ;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_next;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                // Last step: publish this cycle's sum directly so the result lands on the done edge.
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d  = acc_next;
                    overflow_d = |acc_next[2*WIDTH-1:WIDTH];
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign product         = product_q;
    assign productOverflow = overflow_q;
    assign busy            = (state_q == RUN);
    assign done            = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases from the test plan plus
// random operands, compared against plain integer multiplication.
module tb_seq_multiplier;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [W-1:0]     inputP;
    logic [W-1:0]     inputQ;
    logic [2*W-1:0]   product;
    logic             productOverflow;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] last_product;
    logic           last_ovf;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .inputP          (inputP),
        .inputQ          (inputQ),
        .product         (product),
        .productOverflow (productOverflow),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full multiplication. Called right after a done edge it exercises the
    // back-to-back accept. With disturb set, a second start with 2*2 is pulsed
    // at E0+5 and operands are scrambled throughout the run.
    task automatic run_mult(input logic [W-1:0] p, input logic [W-1:0] q, input bit disturb);
        logic [2*W-1:0] exp_product;
        logic           exp_ovf;
        exp_product = 32'(p) * 32'(q);
        exp_ovf     = (exp_product > 32'h0000_FFFF);

        start  = 1'b1;
        inputP = p;
        inputQ = q;
        step();
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_done", 64'(done), 64'd0);
        start = 1'b0;

        for (int i = 1; i < W; i++) begin
            inputP = W'($urandom);
            inputQ = W'($urandom);
            start  = 1'b0;
            if (disturb && i == 5) begin
                start  = 1'b1;
                inputP = 16'd2;
                inputQ = 16'd2;
            end
            step();
            check("run_busy_done", 64'({busy, done}), 64'b10);
            check("run_hold", 64'({productOverflow, product}), 64'({last_ovf, last_product}));
        end
        start = 1'b0;

        step();
        check("done_pulse", 64'({busy, done}), 64'b01);
        check("product", 64'(product), 64'(exp_product));
        check("overflow", 64'(productOverflow), 64'(exp_ovf));
        last_product = exp_product;
        last_ovf     = exp_ovf;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        inputP = '0;
        inputQ = '0;
        last_product = '0;
        last_ovf     = 1'b0;
        step();
        step();
        check("reset_state", 64'({product, productOverflow, busy, done}), 64'd0);
        reset = 1'b0;
        step();
        check("idle_after_reset", 64'({busy, done}), 64'd0);

        // Basic and boundary products.
        run_mult(16'd3, 16'd5, 1'b0);
        check("tp_3x5", 64'(product), 64'h0000_000F);
        run_mult(16'hFFFF, 16'hFFFF, 1'b0);
        check("tp_max", 64'({productOverflow, product}), 64'h1_FFFE_0001);
        run_mult(16'h0100, 16'h0100, 1'b0);
        check("tp_0100sq", 64'({productOverflow, product}), 64'h1_0001_0000);
        run_mult(16'h00FF, 16'h0101, 1'b0);
        check("tp_ffff_fit", 64'({productOverflow, product}), 64'h0_0000_FFFF);
        run_mult(16'h0000, 16'h1234, 1'b0);
        check("tp_zero", 64'({productOverflow, product}), 64'h0);

        // Mid-run start and operand changes are ignored; no extra done follows.
        step();
        run_mult(16'd7, 16'd9, 1'b1);
        check("tp_7x9", 64'(product), 64'd63);
        for (int i = 0; i < 20; i++) begin
            step();
            check("no_extra_done", 64'({busy, done}), 64'd0);
        end
        check("hold_63", 64'(product), 64'd63);

        // Reset mid-run discards the partial result.
        start  = 1'b1;
        inputP = 16'h1234;
        inputQ = 16'h0010;
        step();
        start = 1'b0;
        for (int i = 1; i < 8; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrun_reset", 64'({product, productOverflow, busy, done}), 64'd0);
        last_product = '0;
        last_ovf     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("no_done_after_reset", 64'({busy, done}), 64'd0);
        end
        run_mult(16'h1234, 16'h0010, 1'b0);
        check("tp_after_reset", 64'({productOverflow, product}), 64'h1_0001_2340);

        // Back-to-back: the second start is presented in the done cycle.
        step();
        run_mult(16'd100, 16'd200, 1'b0);
        check("b2b_first", 64'({productOverflow, product}), 64'h0_0000_4E20);
        check("b2b_in_done_cycle", 64'({busy, done}), 64'b01);
        run_mult(16'd300, 16'd400, 1'b0);
        check("b2b_second", 64'({productOverflow, product}), 64'h1_0001_D4C0);

        // Random operands with random idle gaps (including none).
        for (int n = 0; n < 12; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                step();
                check("gap_idle", 64'({busy, done}), 64'd0);
            end
            run_mult(W'($urandom), W'($urandom), n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
